// File: rtl/frame_sync_monitor.sv
// frame_sync_monitor
//   Consumes per-window match / not_match verdicts from the upstream 6-bit
//   sequence detector. It runs a hunt/verify/lock/flywheel machine with
//   hysteresis, keeps saturating statistics, latches a protocol error and
//   watches for a stalled upstream.
//
// Ports
//   clk, rst      : clock; asynchronous active-high reset
//   match         : 1-cycle pulse, window matched
//   not_match     : 1-cycle pulse, window missed (dominates match)
//   clr_stats     : synchronous clear of match_cnt / miss_cnt / err_sticky
//   locked        : high in LOCKED or FLYWHEEL
//   state         : HUNT=0, VERIFY=1, LOCKED=2, FLYWHEEL=3
//   lock_pulse    : entry to LOCKED from HUNT/VERIFY
//   loss_pulse    : exit from LOCKED/FLYWHEEL to HUNT
//   stall_pulse   : idle watchdog expired
//   match_cnt     : saturating count of accepted matches
//   miss_cnt      : saturating count of accepted misses
//   err_sticky    : match and not_match seen high together
module frame_sync_monitor #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int TIMEOUT    = 12,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match,
  input  logic             not_match,
  input  logic             clr_stats,
  output logic             locked,
  output logic [1:0]       state,
  output logic             lock_pulse,
  output logic             loss_pulse,
  output logic             stall_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             err_sticky
);

  localparam logic [1:0] S_HUNT     = 2'd0;
  localparam logic [1:0] S_VERIFY   = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;
  localparam logic [1:0] S_FLYWHEEL = 2'd3;

  localparam logic [3:0]       LOCK_N    = 4'(LOCK_CNT);
  localparam logic [3:0]       UNLOCK_N  = 4'(UNLOCK_CNT);
  // Expiry is decided on the last idle cycle so the pulse lands exactly
  // TIMEOUT idle edges after the last verdict.
  localparam logic [7:0]       IDLE_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       hit_run_q, hit_run_d;
  logic [3:0]       miss_run_q, miss_run_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic             locked_q, locked_d;
  logic             lock_pulse_q, lock_pulse_d;
  logic             loss_pulse_q, loss_pulse_d;
  logic             stall_pulse_q, stall_pulse_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             err_q, err_d;

  logic verdict, is_hit, is_miss;

  // not_match dominates: both high is a miss plus a protocol error.
  assign is_miss = not_match;
  assign is_hit  = match & ~not_match;
  assign verdict = match | not_match;

  always_comb begin
    state_d       = state_q;
    hit_run_d     = hit_run_q;
    miss_run_d    = miss_run_q;
    idle_cnt_d    = idle_cnt_q + 8'd1;
    lock_pulse_d  = 1'b0;
    loss_pulse_d  = 1'b0;
    stall_pulse_d = 1'b0;
    if (verdict) begin
      // A verdict in the expiry cycle wins over the watchdog.
      idle_cnt_d = '0;
      unique case (state_q)
        S_HUNT: begin
          if (is_hit) begin
            if (LOCK_N == 4'd1) begin
              state_d      = S_LOCKED;
              hit_run_d    = '0;
              lock_pulse_d = 1'b1;
            end else begin
              state_d   = S_VERIFY;
              hit_run_d = 4'd1;
            end
          end
        end
        S_VERIFY: begin
          if (is_hit) begin
            if (hit_run_q + 4'd1 == LOCK_N) begin
              state_d      = S_LOCKED;
              hit_run_d    = '0;
              lock_pulse_d = 1'b1;
            end else begin
              hit_run_d = hit_run_q + 4'd1;
            end
          end else begin
            state_d   = S_HUNT;
            hit_run_d = '0;
          end
        end
        S_LOCKED: begin
          if (is_miss) begin
            if (UNLOCK_N == 4'd1) begin
              state_d      = S_HUNT;
              miss_run_d   = '0;
              loss_pulse_d = 1'b1;
            end else begin
              state_d    = S_FLYWHEEL;
              miss_run_d = 4'd1;
            end
          end
        end
        default: begin // S_FLYWHEEL
          if (is_hit) begin
            state_d    = S_LOCKED;
            miss_run_d = '0;
          end else if (miss_run_q + 4'd1 == UNLOCK_N) begin
            state_d      = S_HUNT;
            miss_run_d   = '0;
            loss_pulse_d = 1'b1;
          end else begin
            miss_run_d = miss_run_q + 4'd1;
          end
        end
      endcase
    end else if (idle_cnt_q == IDLE_LAST) begin
      idle_cnt_d    = '0;
      stall_pulse_d = 1'b1;
      loss_pulse_d  = state_q[1]; // LOCKED or FLYWHEEL
      state_d       = S_HUNT;
      hit_run_d     = '0;
      miss_run_d    = '0;
    end
    locked_d = state_d[1];
  end

  always_comb begin
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = err_q;
    if (clr_stats) begin
      // Clear wins over a coincident verdict.
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      err_d       = 1'b0;
    end else begin
      if (is_hit && match_cnt_q != CNT_MAX) match_cnt_d = match_cnt_q + CNT_W'(1);
      if (is_miss && miss_cnt_q != CNT_MAX) miss_cnt_d  = miss_cnt_q + CNT_W'(1);
      if (match && not_match)               err_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HUNT;
      hit_run_q     <= '0;
      miss_run_q    <= '0;
      idle_cnt_q    <= '0;
      locked_q      <= 1'b0;
      lock_pulse_q  <= 1'b0;
      loss_pulse_q  <= 1'b0;
      stall_pulse_q <= 1'b0;
      match_cnt_q   <= '0;
      miss_cnt_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hit_run_q     <= hit_run_d;
      miss_run_q    <= miss_run_d;
      idle_cnt_q    <= idle_cnt_d;
      locked_q      <= locked_d;
      lock_pulse_q  <= lock_pulse_d;
      loss_pulse_q  <= loss_pulse_d;
      stall_pulse_q <= stall_pulse_d;
      match_cnt_q   <= match_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      err_q         <= err_d;
    end
  end

  assign state       = state_q;
  assign locked      = locked_q;
  assign lock_pulse  = lock_pulse_q;
  assign loss_pulse  = loss_pulse_q;
  assign stall_pulse = stall_pulse_q;
  assign match_cnt   = match_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_frame_sync_monitor.sv
// Bench for frame_sync_monitor: a default instance (a) and a corner instance
// (b: CNT_W=2, LOCK_CNT=1, UNLOCK_CNT=1, TIMEOUT=7) share the same stimulus,
// each checked every cycle against a behavioural model of the rules.
module tb_frame_sync_monitor;
  logic clk = 1'b0;
  logic rst, match, not_match, clr_stats;

  logic a_locked, a_lp, a_lsp, a_sp, a_err;
  logic [1:0] a_state;
  logic [15:0] a_mc, a_xc;
  logic b_locked, b_lp, b_lsp, b_sp, b_err;
  logic [1:0] b_state;
  logic [1:0] b_mc, b_xc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  frame_sync_monitor #(.LOCK_CNT(3), .UNLOCK_CNT(2), .TIMEOUT(12), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .match(match), .not_match(not_match), .clr_stats(clr_stats),
    .locked(a_locked), .state(a_state), .lock_pulse(a_lp), .loss_pulse(a_lsp),
    .stall_pulse(a_sp), .match_cnt(a_mc), .miss_cnt(a_xc), .err_sticky(a_err));

  frame_sync_monitor #(.LOCK_CNT(1), .UNLOCK_CNT(1), .TIMEOUT(7), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .match(match), .not_match(not_match), .clr_stats(clr_stats),
    .locked(b_locked), .state(b_state), .lock_pulse(b_lp), .loss_pulse(b_lsp),
    .stall_pulse(b_sp), .match_cnt(b_mc), .miss_cnt(b_xc), .err_sticky(b_err));

  typedef struct {
    int st;     // 0 hunt, 1 verify, 2 locked, 3 flywheel
    int hits;   // consecutive matches while hunting/verifying
    int misses; // consecutive misses since lock was threatened
    int idle;   // idle cycles since last verdict
    int mc, xc;
    bit err, lp, lsp, sp;
  } m_t;

  m_t ma, mb;

  function automatic m_t m_reset();
    m_t m;
    m.st = 0; m.hits = 0; m.misses = 0; m.idle = 0;
    m.mc = 0; m.xc = 0; m.err = 0; m.lp = 0; m.lsp = 0; m.sp = 0;
    return m;
  endfunction

  function automatic m_t step(m_t m, bit mt, bit nm, bit clr,
                              int lc, int uc, int tmo, int maxc);
    m_t n = m;
    bit hit = mt && !nm;
    n.lp = 0; n.lsp = 0; n.sp = 0;
    if (mt || nm) begin
      n.idle = 0;
      if (m.st < 2) begin
        if (hit) begin
          n.hits = (m.st == 0) ? 1 : m.hits + 1;
          if (n.hits >= lc) begin n.st = 2; n.lp = 1; n.hits = 0; end
          else n.st = 1;
        end else begin
          n.st = 0; n.hits = 0;
        end
      end else begin
        if (hit) begin
          n.st = 2; n.misses = 0;
        end else begin
          n.misses = m.misses + 1;
          if (n.misses >= uc) begin n.st = 0; n.lsp = 1; n.misses = 0; end
          else n.st = 3;
        end
      end
    end else begin
      n.idle = m.idle + 1;
      if (n.idle == tmo) begin
        n.sp = 1; n.lsp = (m.st >= 2);
        n.st = 0; n.hits = 0; n.misses = 0; n.idle = 0;
      end
    end
    if (clr) begin
      n.mc = 0; n.xc = 0; n.err = 0;
    end else begin
      if (hit && m.mc < maxc) n.mc = m.mc + 1;
      if (nm && m.xc < maxc)  n.xc = m.xc + 1;
      if (mt && nm) n.err = 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("a_state", 32'(a_state), 32'(ma.st));
    chk("a_locked", 32'(a_locked), 32'(ma.st >= 2));
    chk("a_pulses", {29'd0, a_lp, a_lsp, a_sp}, {29'd0, ma.lp, ma.lsp, ma.sp});
    chk("a_match_cnt", 32'(a_mc), 32'(ma.mc));
    chk("a_miss_cnt", 32'(a_xc), 32'(ma.xc));
    chk("a_err", 32'(a_err), 32'(ma.err));
    chk("b_state", 32'(b_state), 32'(mb.st));
    chk("b_locked", 32'(b_locked), 32'(mb.st >= 2));
    chk("b_pulses", {29'd0, b_lp, b_lsp, b_sp}, {29'd0, mb.lp, mb.lsp, mb.sp});
    chk("b_match_cnt", 32'(b_mc), 32'(mb.mc));
    chk("b_miss_cnt", 32'(b_xc), 32'(mb.xc));
    chk("b_err", 32'(b_err), 32'(mb.err));
  endtask

  // Drive one cycle of inputs, let the edge happen, then check both DUTs.
  task automatic cyc(input bit mt, input bit nm, input bit clr);
    match = mt; not_match = nm; clr_stats = clr;
    @(posedge clk);
    #1;
    ma = step(ma, mt, nm, clr, 3, 2, 12, 65535);
    mb = step(mb, mt, nm, clr, 1, 1, 7, 3);
    match = 0; not_match = 0; clr_stats = 0;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must clear without an edge.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    ma = m_reset(); mb = m_reset();
    chk_all();
    chk("rst_no_loss", {31'd0, a_lsp | b_lsp}, 32'd0);
    #2 rst = 1'b0;
  endtask

  task automatic lock_a();
    for (int i = 0; i < 3; i++) begin cyc(1, 0, 0); idle(5); end
  endtask

  initial begin
    rst = 1'b1; match = 0; not_match = 0; clr_stats = 0;
    ma = m_reset(); mb = m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;

    // Three matches six cycles apart lock instance a.
    cyc(1, 0, 0); chk("t1_verify", 32'(a_state), 32'd1); idle(5);
    cyc(1, 0, 0); chk("t1_verify2", 32'(a_state), 32'd1); idle(5);
    cyc(1, 0, 0);
    chk("t1_lock_state", 32'(a_state), 32'd2);
    chk("t1_lock_pulse", 32'(a_lp), 32'd1);
    chk("t1_match_cnt", 32'(a_mc), 32'd3);
    chk("b_sat_early", 32'(b_mc), 32'd3);
    idle(5);

    // Miss, match, miss, miss: flywheel recovery then loss.
    cyc(0, 1, 0); chk("t2_fly", 32'(a_state), 32'd3); idle(5);
    cyc(1, 0, 0); chk("t2_relock_no_lp", {30'd0, a_state}, 32'd2);
    chk("t2_no_lock_pulse", 32'(a_lp), 32'd0); idle(5);
    cyc(0, 1, 0); idle(5);
    cyc(0, 1, 0);
    chk("t2_loss", 32'(a_lsp), 32'd1);
    chk("t2_hunt", 32'(a_state), 32'd0);
    chk("t2_miss_cnt", 32'(a_xc), 32'd3);
    idle(5);

    // Verify broken by a miss, then three fresh matches needed.
    cyc(1, 0, 0); idle(2); cyc(1, 0, 0); idle(2); cyc(0, 1, 0);
    chk("t3_back_hunt", 32'(a_state), 32'd0);
    cyc(1, 0, 0); idle(2); cyc(1, 0, 0); idle(2);
    chk("t3_not_yet", 32'(a_state), 32'd1);
    cyc(1, 0, 0);
    chk("t3_lock", 32'(a_state), 32'd2);
    idle(5);

    // Watchdog: 12 idle cycles stall and drop lock.
    cyc(1, 0, 0);
    idle(12);
    chk("t4_stall", 32'(a_sp), 32'd1);
    chk("t4_loss", 32'(a_lsp), 32'd1);
    chk("t4_hunt", 32'(a_state), 32'd0);
    lock_a();
    cyc(1, 0, 0);
    idle(11);
    cyc(1, 0, 0);
    chk("t4_no_stall", 32'(a_sp), 32'd0);
    chk("t4_still_locked", 32'(a_state), 32'd2);

    // Both inputs high while locked.
    cyc(1, 1, 0);
    chk("t5_err", 32'(a_err), 32'd1);
    chk("t5_fly", 32'(a_state), 32'd3);
    idle(2);
    cyc(1, 0, 1);
    chk("t5_clr_mc", 32'(a_mc), 32'd0);
    chk("t5_clr_xc", 32'(a_xc), 32'd0);
    chk("t5_clr_err", 32'(a_err), 32'd0);

    // Saturation on the narrow instance, then reset while a is in flywheel.
    for (int i = 0; i < 5; i++) begin cyc(1, 0, 0); idle(3); end
    chk("t6_b_sat", 32'(b_mc), 32'd3);
    cyc(0, 1, 0);
    chk("t6_a_fly", 32'(a_state), 32'd3);
    async_reset();

    // Randomized traffic with occasional clears, idle gaps and resets.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else if ($urandom_range(0, 199) == 0) begin
        idle($urandom_range(5, 14));
      end else begin
        cyc(r < 12 || (r >= 16 && r < 18), r >= 12 && r < 18, $urandom_range(0, 99) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
